// File: rtl/gray_pkg.sv
// Shared definitions for the binary/Gray conversion scheduler and its clients.
package gray_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CONV = 2'd1,
      RESP = 2'd2
   } state_t;

   localparam logic MODE_B2G = 1'b0;
   localparam logic MODE_G2B = 1'b1;

   // Widest operand the shared helper handles; callers zero-extend and truncate.
   localparam int GRAY_MAXW = 64;

   function automatic logic [GRAY_MAXW-1:0] bin2gray(input logic [GRAY_MAXW-1:0] bin);
      return bin ^ (bin >> 1);
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first set request at or above ptr, wrapping.
module rr_arbiter #(
   parameter int NREQ = 4,
   parameter int IDW  = $clog2(NREQ)
) (
   input  logic [NREQ-1:0] req,
   input  logic [IDW-1:0]  ptr,
   output logic [NREQ-1:0] grant,
   output logic [IDW-1:0]  idx,
   output logic            any
);

   logic [NREQ-1:0] rot;
   logic [IDW-1:0]  pos [NREQ];

   generate
      for (genvar gi = 0; gi < NREQ; gi++) begin : g_rot
         logic [IDW:0] sum;
         // pos is (ptr + gi) mod NREQ, assuming ptr is always below NREQ
         assign sum     = {1'b0, ptr} + (IDW+1)'(gi);
         assign pos[gi] = (sum >= (IDW+1)'(NREQ)) ? IDW'(sum - (IDW+1)'(NREQ)) : sum[IDW-1:0];
         assign rot[gi] = req[pos[gi]];
      end
   endgenerate

   always_comb begin
      idx   = '0;
      any   = 1'b0;
      for (int k = NREQ - 1; k >= 0; k--) begin
         if (rot[k]) begin
            idx = pos[k];
            any = 1'b1;
         end
      end
      grant = any ? (NREQ'(1) << idx) : '0;
   end

endmodule

// File: rtl/gray_conv_sched.sv
// Round-robin shared binary<->Gray engine: one-cycle b2g, serial MSB-first g2b,
// single tagged valid/ready response channel.
module gray_conv_sched
   import gray_pkg::*;
#(
   parameter int WIDTH = 4,
   parameter int NREQ  = 4,
   localparam int IDW  = $clog2(NREQ)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [NREQ-1:0]       req_valid,
   input  logic [NREQ-1:0]       req_mode,
   input  logic [NREQ*WIDTH-1:0] req_data,
   output logic [NREQ-1:0]       req_ready,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [IDW-1:0]        rsp_id,
   output logic                  rsp_mode,
   output logic [WIDTH-1:0]      rsp_data,
   output logic                  busy
);

   localparam int CW = $clog2(WIDTH);

   state_t           state_reg, state_next;
   logic [IDW-1:0]   ptr_reg;
   logic [IDW-1:0]   id_reg;
   logic             mode_reg;
   logic [WIDTH-1:0] gin_reg;
   logic [WIDTH-1:0] acc_reg, acc_next;
   logic [CW-1:0]    cnt_reg;
   logic             rsp_valid_reg;
   logic [IDW-1:0]   rsp_id_reg;
   logic             rsp_mode_reg;
   logic [WIDTH-1:0] rsp_data_reg;

   logic [NREQ-1:0]  grant;
   logic [IDW-1:0]   gidx;
   logic             gany;
   logic             accept;
   logic             last_step;
   logic [CW-1:0]    bit_lo, bit_hi;
   logic [WIDTH-1:0] gray_val;

   rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (
      .req   (req_valid),
      .ptr   (ptr_reg),
      .grant (grant),
      .idx   (gidx),
      .any   (gany)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_reg <= IDLE;
      else        state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (gany)      state_next = CONV;
         CONV:    if (last_step) state_next = RESP;
         RESP:    if (rsp_ready) state_next = IDLE;
         default:                state_next = IDLE;
      endcase
   end

   always_comb begin
      req_ready = (state_reg == IDLE && rst_n) ? grant : '0;
      busy      = (state_reg != IDLE);
      accept    = (state_reg == IDLE) && gany;
   end

   // Serial g2b: step k = cnt+1 resolves bit WIDTH-1-k from the bit above it.
   assign last_step = (mode_reg == MODE_B2G) || (cnt_reg == CW'(WIDTH - 2));
   assign bit_lo    = CW'(WIDTH - 2) - cnt_reg;
   assign bit_hi    = bit_lo + CW'(1);
   assign gray_val  = WIDTH'(bin2gray(GRAY_MAXW'(gin_reg)));

   always_comb begin
      acc_next         = acc_reg;
      acc_next[bit_lo] = acc_reg[bit_hi] ^ gin_reg[bit_lo];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_reg  <= '0;
         id_reg   <= '0;
         mode_reg <= MODE_B2G;
         gin_reg  <= '0;
         acc_reg  <= '0;
         cnt_reg  <= '0;
      end else if (accept) begin
         ptr_reg  <= (gidx == IDW'(NREQ - 1)) ? '0 : gidx + IDW'(1);
         id_reg   <= gidx;
         mode_reg <= req_mode[gidx];
         gin_reg  <= req_data[gidx*WIDTH +: WIDTH];
         acc_reg  <= {req_data[gidx*WIDTH + WIDTH - 1], {(WIDTH-1){1'b0}}};
         cnt_reg  <= '0;
      end else if (state_reg == CONV && mode_reg == MODE_G2B) begin
         acc_reg  <= acc_next;
         cnt_reg  <= last_step ? '0 : cnt_reg + CW'(1);
      end
   end

   // Response registers are loaded once per op so they hold across the next accept.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rsp_valid_reg <= 1'b0;
         rsp_id_reg    <= '0;
         rsp_mode_reg  <= 1'b0;
         rsp_data_reg  <= '0;
      end else if (state_reg == CONV && last_step) begin
         rsp_valid_reg <= 1'b1;
         rsp_id_reg    <= id_reg;
         rsp_mode_reg  <= mode_reg;
         rsp_data_reg  <= (mode_reg == MODE_B2G) ? gray_val : acc_next;
      end else if (state_reg == RESP && rsp_ready) begin
         rsp_valid_reg <= 1'b0;
      end
   end

   assign rsp_valid = rsp_valid_reg;
   assign rsp_id    = rsp_id_reg;
   assign rsp_mode  = rsp_mode_reg;
   assign rsp_data  = rsp_data_reg;

endmodule
